// File: rtl/cycle_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cycle_run_ctrl_if
//
// Purpose: groups the control/status signals of cycle_run_ctrl into one
// bundle. The clock and the active-low reset stay plain ports on the
// controller itself.
//
// Signals:
//   start        arm a run from IDLE or DONE (pulse)
//   abort        return to IDLE from any state
//   mode[1:0]    0 fixed count, 1 until halt, 2 single-step, 3 same as 0
//   use_default  substitute DEFAULT_LIMIT when cycle_limit == 0
//   cycle_limit  maximum number of enabled cycles for the run
//   step         single-step grant (mode 2)
//   halt_in      halt indication from the core
//   cpu_reset    active-high reset to the core
//   cpu_clk_en   clock enable to the core
//   cycle_count  enabled cycles elapsed in RUN
//   running      controller is in RUN
//   done         controller is in DONE
//   timeout      mode-1 run ended by the limit
//
// Optional (CYCLE_RUN_CTRL_BREAK_EN defined):
//   pc_in, break_pc  current core PC and breakpoint address
//   break_hit        run ended on the breakpoint
//
// Modports: master drives the controls (bench/board logic), slave is the
// controller.
// ---------------------------------------------------------------------------
interface cycle_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic             use_default;
    logic [CNT_W-1:0] cycle_limit;
    logic             step;
    logic             halt_in;
    logic             cpu_reset;
    logic             cpu_clk_en;
    logic [CNT_W-1:0] cycle_count;
    logic             running;
    logic             done;
    logic             timeout;
`ifdef CYCLE_RUN_CTRL_BREAK_EN
    logic [31:0]      pc_in;
    logic [31:0]      break_pc;
    logic             break_hit;
`endif

    modport master (
        output start, abort, mode, use_default, cycle_limit, step, halt_in,
`ifdef CYCLE_RUN_CTRL_BREAK_EN
        output pc_in, break_pc,
        input  break_hit,
`endif
        input  cpu_reset, cpu_clk_en, cycle_count, running, done, timeout
    );

    modport slave (
        input  start, abort, mode, use_default, cycle_limit, step, halt_in,
`ifdef CYCLE_RUN_CTRL_BREAK_EN
        input  pc_in, break_pc,
        output break_hit,
`endif
        output cpu_reset, cpu_clk_en, cycle_count, running, done, timeout
    );
endinterface

// File: rtl/cycle_run_ctrl.sv
// ---------------------------------------------------------------------------
// cycle_run_ctrl
//
// Purpose: sequences a core under test through reset, execution and stop.
// A start pulse arms a run: the core is held in clocked reset for
// RESET_CYCLES edges, then executes under one of four modes (fixed count,
// until-halt with timeout, single-step, reserved = fixed count) until the
// run ends or is aborted. Cycle count and run status are exposed for
// checking by a bench or board logic.
//
// Ports:
//   clock  single system clock
//   reset  synchronous, active-low reset
//   bus    cycle_run_ctrl_if.slave (controls in, core enables/status out)
//
// Parameters:
//   CNT_W          width of cycle counter and cycle_limit
//   RESET_CYCLES   edges for which cpu_reset is held after arming (>= 1)
//   DEFAULT_LIMIT  limit used when cycle_limit == 0 and use_default == 1
//
// Optional feature: define CYCLE_RUN_CTRL_BREAK_EN to add a PC breakpoint
// (pc_in / break_pc / break_hit on the interface). Without it the
// breakpoint logic is absent.
// ---------------------------------------------------------------------------
module cycle_run_ctrl #(
    parameter int CNT_W         = 32,
    parameter int RESET_CYCLES  = 2,
    parameter int DEFAULT_LIMIT = 150
) (
    input  logic             clock,
    input  logic             reset,
    cycle_run_ctrl_if.slave  bus
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD_RST = 2'd1,
        S_RUN      = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t            state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [1:0]        mode_reg;
    logic [CNT_W-1:0]  limit_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              timeout_reg;
    logic              cpu_reset_reg;
    logic              running_reg;
    logic              done_reg;

    // Values captured on the arming edge. Mode 3 is folded onto mode 0 here
    // so the rest of the logic only ever sees modes 0..2.
    logic [CNT_W-1:0]  arm_limit;
    logic [1:0]        arm_mode;
    assign arm_limit = (bus.cycle_limit == '0 && bus.use_default)
                     ? CNT_W'(DEFAULT_LIMIT) : bus.cycle_limit;
    assign arm_mode  = (bus.mode == 2'd3) ? 2'd0 : bus.mode;

    // An enabled RUN cycle: always in modes 0/1, only with a step grant in
    // mode 2. This is the one combinational path to the core.
    logic run_en;
    assign run_en = (state_reg == S_RUN) && ((mode_reg != 2'd2) || bus.step);

    logic [CNT_W-1:0] count_inc;
    assign count_inc = count_reg + CNT_W'(1);

    // Run-ending conditions, evaluated at the coming edge.
    logic limit_hit;
    logic halt_end;
    logic break_end;
    assign limit_hit = run_en && (count_inc == limit_reg);
    // Halt ends the run in modes 1 and 2 even on a non-stepped cycle; it is
    // only counted when the cycle is enabled.
    assign halt_end  = (state_reg == S_RUN) && (mode_reg != 2'd0) && bus.halt_in;

`ifdef CYCLE_RUN_CTRL_BREAK_EN
    logic [31:0] break_pc_reg;
    logic        break_hit_reg;
    assign break_end     = run_en && (bus.pc_in == break_pc_reg);
    assign bus.break_hit = break_hit_reg;
`else
    assign break_end = 1'b0;
`endif

    assign bus.cpu_clk_en  = (state_reg == S_HOLD_RST) || run_en;
    assign bus.cpu_reset   = cpu_reset_reg;
    assign bus.cycle_count = count_reg;
    assign bus.running     = running_reg;
    assign bus.done        = done_reg;
    assign bus.timeout     = timeout_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            hold_cnt_reg  <= '0;
            mode_reg      <= 2'd0;
            limit_reg     <= '0;
            count_reg     <= '0;
            timeout_reg   <= 1'b0;
            cpu_reset_reg <= 1'b1;
            running_reg   <= 1'b0;
            done_reg      <= 1'b0;
`ifdef CYCLE_RUN_CTRL_BREAK_EN
            break_pc_reg  <= '0;
            break_hit_reg <= 1'b0;
`endif
        end else if (bus.abort) begin
            // Like reset, except the count of the aborted run stays visible.
            state_reg     <= S_IDLE;
            hold_cnt_reg  <= '0;
            timeout_reg   <= 1'b0;
            cpu_reset_reg <= 1'b1;
            running_reg   <= 1'b0;
            done_reg      <= 1'b0;
`ifdef CYCLE_RUN_CTRL_BREAK_EN
            break_hit_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_reg     <= S_HOLD_RST;
                        hold_cnt_reg  <= '0;
                        mode_reg      <= arm_mode;
                        limit_reg     <= arm_limit;
                        count_reg     <= '0;
                        timeout_reg   <= 1'b0;
                        cpu_reset_reg <= 1'b1;
                        running_reg   <= 1'b0;
                        done_reg      <= 1'b0;
`ifdef CYCLE_RUN_CTRL_BREAK_EN
                        break_pc_reg  <= bus.break_pc;
                        break_hit_reg <= 1'b0;
`endif
                    end
                end

                S_HOLD_RST: begin
                    hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    if (hold_cnt_reg == HOLD_W'(RESET_CYCLES - 1)) begin
                        cpu_reset_reg <= 1'b0;
                        // A zero limit means there is nothing to run.
                        if (limit_reg == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= S_RUN;
                            running_reg <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (run_en) begin
                        count_reg <= count_inc;
                    end
                    if (halt_end || break_end || limit_hit) begin
                        state_reg   <= S_DONE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        // Halt and breakpoint both outrank the limit.
                        timeout_reg <= limit_hit && !halt_end && !break_end
                                       && (mode_reg == 2'd1);
`ifdef CYCLE_RUN_CTRL_BREAK_EN
                        break_hit_reg <= break_end && !halt_end;
`endif
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_run_ctrl.sv
module tb_cycle_run_ctrl;

    localparam int CNT_W   = 32;
    localparam int RST_CYC = 2;
    localparam int DEF_LIM = 150;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    cycle_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    cycle_run_ctrl #(
        .CNT_W         (CNT_W),
        .RESET_CYCLES  (RST_CYC),
        .DEFAULT_LIMIT (DEF_LIM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.mode        = 2'd0;
        bus.use_default = 1'b0;
        bus.cycle_limit = '0;
        bus.step        = 1'b0;
        bus.halt_in     = 1'b0;
`ifdef CYCLE_RUN_CTRL_BREAK_EN
        bus.pc_in       = 32'h0;
        bus.break_pc    = 32'hFFFF_FFFF;
`endif
    endtask

    // One complete run from IDLE or DONE, checked cycle by cycle against a
    // model that only knows the rules: hold reset, count enabled cycles,
    // stop at limit or (modes 1/2) at halt.
    //   step_kind : 0 step low, 1 step on alternate cycles, 2 random step
    //   halt_at   : enabled-cycle number during which halt_in is raised (0 = never)
    //   glitch_at : RUN cycle index in which a stray start pulse is given (-1 = none)
    task automatic run_scenario(input int md, input int lim, input bit ud,
                                input int halt_at, input int step_kind,
                                input int glitch_at, input string tag);
        int  md_eff;
        int  eff_lim;
        int  c;
        bit  en;
        bit  h;
        bit  ended;
        bit  exp_to;
        int  n;
        md_eff  = (md == 3) ? 0 : md;
        eff_lim = (lim == 0 && ud) ? DEF_LIM : lim;
        bus.mode        = 2'(md);
        bus.cycle_limit = CNT_W'(lim);
        bus.use_default = ud;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        // Inputs are only sampled on the arming edge: scramble them now.
        bus.mode        = 2'($urandom_range(0, 3));
        bus.cycle_limit = CNT_W'($urandom_range(1, 9));
        bus.use_default = ~ud;

        for (int i = 0; i < RST_CYC; i++) begin
            checks++;
            if (bus.cpu_reset !== 1'b1 || bus.cpu_clk_en !== 1'b1 || bus.running !== 1'b0
                || bus.cycle_count !== '0) begin
                errors++;
                $display("FAIL %s hold[%0d]: rst=%b en=%b run=%b cnt=%0d, required rst=1 en=1 run=0 cnt=0",
                         tag, i, bus.cpu_reset, bus.cpu_clk_en, bus.running, bus.cycle_count);
            end
            tick();
        end

        c      = 0;
        exp_to = 1'b0;
        ended  = (eff_lim == 0);
        n      = 0;
        while (!ended && n < 4000) begin
            case (step_kind)
                1:       bus.step = (n % 2 == 0);
                2:       bus.step = 1'($urandom_range(0, 1));
                default: bus.step = 1'b0;
            endcase
            en = (md_eff != 2) || bus.step;
            h  = en && (halt_at != 0) && (c + 1 == halt_at);
            bus.halt_in = h;
            bus.start   = (n == glitch_at);
            #1;
            checks++;
            if (bus.cpu_clk_en !== en || bus.running !== 1'b1 || bus.cpu_reset !== 1'b0
                || bus.done !== 1'b0 || bus.cycle_count !== CNT_W'(c)) begin
                errors++;
                $display("FAIL %s run[%0d]: en=%b run=%b rst=%b done=%b cnt=%0d, required en=%b run=1 rst=0 done=0 cnt=%0d",
                         tag, n, bus.cpu_clk_en, bus.running, bus.cpu_reset, bus.done,
                         bus.cycle_count, en, c);
            end
            tick();
            if (en) c++;
            if (md_eff != 0 && h) begin
                ended = 1'b1;
            end else if (c == eff_lim) begin
                ended  = 1'b1;
                exp_to = (md_eff == 1);
            end
            n++;
        end
        bus.step    = 1'b0;
        bus.halt_in = 1'b0;
        bus.start   = 1'b0;

        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL %s budget: run still open after %0d cycles, required end", tag, n);
        end

        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.running !== 1'b0 || bus.cpu_reset !== 1'b0
            || bus.cycle_count !== CNT_W'(c) || bus.timeout !== exp_to) begin
            errors++;
            $display("FAIL %s end: done=%b run=%b rst=%b cnt=%0d to=%b, required done=1 run=0 rst=0 cnt=%0d to=%b",
                     tag, bus.done, bus.running, bus.cpu_reset, bus.cycle_count, bus.timeout, c, exp_to);
        end

        // DONE is sticky and gives the core no further enables.
        for (int i = 0; i < 4; i++) begin
            bus.step    = (i % 2 == 0);
            bus.halt_in = (i == 1);
            #1;
            checks++;
            if (bus.cpu_clk_en !== 1'b0 || bus.done !== 1'b1 || bus.cycle_count !== CNT_W'(c)
                || bus.timeout !== exp_to) begin
                errors++;
                $display("FAIL %s hold_done[%0d]: en=%b done=%b cnt=%0d to=%b, required en=0 done=1 cnt=%0d to=%b",
                         tag, i, bus.cpu_clk_en, bus.done, bus.cycle_count, bus.timeout, c, exp_to);
            end
            tick();
        end
        bus.step    = 1'b0;
        bus.halt_in = 1'b0;
        $display("run %s: mode=%0d limit=%0d ud=%0d halt_at=%0d -> count=%0d timeout=%0d",
                 tag, md, lim, ud, halt_at, c, exp_to);
    endtask

    // Start a mode-0 run and let it execute `cycles` enabled cycles.
    task automatic open_run(input int lim, input int cycles);
        bus.mode        = 2'd0;
        bus.cycle_limit = CNT_W'(lim);
        bus.use_default = 1'b0;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (RST_CYC + cycles) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.cpu_reset !== 1'b1 || bus.cpu_clk_en !== 1'b0 || bus.cycle_count !== '0
            || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: rst=%b en=%b cnt=%0d run=%b done=%b to=%b, required 1 0 0 0 0 0",
                     bus.cpu_reset, bus.cpu_clk_en, bus.cycle_count, bus.running, bus.done, bus.timeout);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.cpu_reset !== 1'b1 || bus.cpu_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL idle: rst=%b en=%b, required rst=1 en=0", bus.cpu_reset, bus.cpu_clk_en);
        end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_default_run();
        run_scenario(0, 0, 1'b1, 0, 0, -1, "default");
    endtask

    task automatic test_halt();
        run_scenario(1, 1000, 1'b0, 37, 0, -1, "halt");
    endtask

    task automatic test_timeout();
        run_scenario(1, 20, 1'b0, 0, 0, -1, "timeout");
        run_scenario(1, 20, 1'b0, 20, 0, -1, "halt_on_limit");
    endtask

    task automatic test_single_step();
        run_scenario(2, 5, 1'b0, 0, 1, -1, "single_step");
        run_scenario(2, 9, 1'b0, 4, 2, -1, "step_halt");
    endtask

    task automatic test_abort();
        open_run(100, 40);
        bus.abort = 1'b1;
        bus.start = 1'b1;   // abort outranks start
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.cpu_reset !== 1'b1 || bus.cpu_clk_en !== 1'b0 || bus.running !== 1'b0
            || bus.done !== 1'b0 || bus.timeout !== 1'b0 || bus.cycle_count !== CNT_W'(40)) begin
            errors++;
            $display("FAIL abort: rst=%b en=%b run=%b done=%b to=%b cnt=%0d, required 1 0 0 0 0 40",
                     bus.cpu_reset, bus.cpu_clk_en, bus.running, bus.done, bus.timeout, bus.cycle_count);
        end
        $display("abort: at count 40");
        run_scenario(0, 12, 1'b0, 0, 0, -1, "after_abort");
    endtask

    task automatic test_reset_mid_run();
        open_run(100, 40);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (bus.cycle_count !== '0 || bus.cpu_reset !== 1'b1 || bus.running !== 1'b0
            || bus.done !== 1'b0 || bus.cpu_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: cnt=%0d rst=%b run=%b done=%b en=%b, required 0 1 0 0 0",
                     bus.cycle_count, bus.cpu_reset, bus.running, bus.done, bus.cpu_clk_en);
        end
        $display("reset_mid_run: at count 40");
    endtask

    task automatic test_limit_zero_rearm();
        run_scenario(0, 0, 1'b0, 0, 0, -1, "limit_zero");
        run_scenario(0, 10, 1'b0, 0, 0, 3, "rearm_glitch");
        run_scenario(3, 7, 1'b0, 2, 0, -1, "mode3");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int md;
            int lim;
            int ha;
            md  = $urandom_range(0, 3);
            lim = $urandom_range(1, 40);
            ha  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 45);
            run_scenario(md, lim, 1'($urandom_range(0, 1)), ha, 2,
                         ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1, "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        idle_inputs();
        test_reset();
        test_default_run();
        test_halt();
        test_timeout();
        test_single_step();
        test_abort();
        test_reset_mid_run();
        test_limit_zero_rearm();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
